energy_telemetry_tx: RTL and testbench
======================================

Name: energy_telemetry_tx

Overview:
- Downstream consumer of the data_collector converted-voltage byte stream.
- Block-averages 2^LOG2_WIN samples and buffers each average in a small FIFO.
- Serialises buffered averages on a single UART-style 8N1 line for off-chip logging.
- Sits between data_collector output and a spare output pin of the top level.

Parameters:
LOG2_WIN, 3, log2 of samples per average window (window = 8 samples)
CLKS_PER_BIT, 16, clk cycles per serial bit (must be >= 2)
FIFO_DEPTH, 4, entries in average FIFO (power of two, >= 2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sample_in  in  8  converted voltage sample, unsigned
sample_valid  in  1  one-cycle strobe; sample_in captured when high
clear_ovf  in  1  synchronous clear of overflow flag
avg_out  out  8  most recent window average
avg_valid  out  1  one-cycle pulse when avg_out updates
tx  out  1  serial output, idle high
overflow  out  1  sticky: an average was dropped because FIFO was full
busy  out  1  high while FIFO non-empty or a frame is in progress

Behaviour:
- Reset (async assert, sync-safe deassert handled by top): acc=0, count=0, avg_out=0, avg_valid=0, FIFO empty, overflow=0, tx=1, busy=0, TX state IDLE. Reset mid-frame aborts the frame; tx goes high immediately.
- Accumulator is 8+LOG2_WIN bits wide and cannot overflow. On sample_valid with count < 2^LOG2_WIN-1: acc += sample_in, count++.
- On sample_valid with count == 2^LOG2_WIN-1: avg = (acc + sample_in) >> LOG2_WIN (truncating), registered into avg_out. avg_valid pulses on the next cycle (1-cycle latency from the final strobe). acc and count clear to 0.
- avg_valid cycle = FIFO push of avg_out.
- Push when full and no pop that cycle: new average dropped, FIFO unchanged, overflow set.
- Push and pop in the same cycle on a full FIFO: both occur, no overflow.
- clear_ovf clears overflow. If an overflow occurs in the same cycle, set wins.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. If FIFO non-empty, pop head into shift register, reset bit timer, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; bit index counts 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Frame = 10*CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly 1 IDLE cycle.
- busy = (state != IDLE) | FIFO non-empty, combinational from registers.
- sample_valid is accepted every cycle, including consecutive cycles. Averaging never stalls for TX.
- FIFO pointers are LOG2(FIFO_DEPTH)+1 bits; the extra MSB distinguishes full from empty; wrap-around is modulo depth.

Test Plan:
- Reset then 8 strobes of sample_in=0x40 -> avg_out=0x40, avg_valid pulses 1 cycle after 8th strobe; tx frame start bit begins within 2 cycles; decoded byte 0x40, 160 cycles frame.
- Samples 0xFF x7 then 0xFE -> acc=0x7F8+... sum 0x7F7, avg_out=0xFE (truncation); no accumulator wrap.
- 6 windows back-to-back with strobes every cycle (averages 0x01..0x06) -> first average transmits immediately, next 4 buffered, 6th dropped, overflow=1; serial bytes 0x01..0x05 in order; busy falls 1 cycle after last STOP.
- overflow=1, assert clear_ovf alone -> overflow=0; assert clear_ovf in the same cycle as a drop -> overflow stays 1.
- FIFO full with pop and push in the same cycle -> no overflow; all entries transmitted in order; pointers wrap correctly over 3x depth pushes.
- rst_n low during DATA bit 3 -> tx=1 immediately, busy=0, FIFO empty; after release, a new window of 0x10 transmits as clean byte 0x10.

Source files
------------

// File: rtl/energy_telemetry_tx.sv
// Block-averages the converted-voltage sample stream, buffers each average in a small FIFO
// and serialises the buffered averages as 8N1 frames on a single output line.
module energy_telemetry_tx #(
   parameter int unsigned LOG2_WIN     = 3,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   input  logic       clear_ovf,
   output logic [7:0] avg_out,
   output logic       avg_valid,
   output logic       tx,
   output logic       overflow,
   output logic       busy
);

   localparam int unsigned ACC_W = 8 + LOG2_WIN;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
   localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;
   localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

   // ---------------- window averaging ----------------
   logic [ACC_W-1:0]    acc_q;
   logic [LOG2_WIN-1:0] count_q;
   logic [7:0]          avg_q;
   logic                avg_valid_q;
   logic [ACC_W-1:0]    sum;

   assign sum = acc_q + ACC_W'(sample_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         count_q     <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
      end else begin
         avg_valid_q <= 1'b0;
         if (sample_valid) begin
            if (count_q == CNT_LAST) begin
               avg_q       <= 8'(sum >> LOG2_WIN);
               avg_valid_q <= 1'b1;
               acc_q       <= '0;
               count_q     <= '0;
            end else begin
               acc_q   <= sum;
               count_q <= count_q + LOG2_WIN'(1);
            end
         end
      end
   end

   assign avg_out   = avg_q;
   assign avg_valid = avg_valid_q;

   // ---------------- average FIFO ----------------
   logic [7:0]     mem_q [FIFO_DEPTH];
   logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
   logic           empty, full, push, pop, push_ok, drop, ovf_q;
   tx_state_e      state_q, state_d;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign pop     = (state_q == StIdle) && !empty;
   assign push    = avg_valid_q;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= avg_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
         if (drop)           ovf_q <= 1'b1;
         else if (clear_ovf) ovf_q <= 1'b0;
      end
   end

   assign overflow = ovf_q;

   // ---------------- serial transmitter ----------------
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             bit_done;

   assign bit_done = (timer_q == TMR_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + TMR_W'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx        = 1'b1;
      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (!empty) begin
               shift_d = mem_q[rd_ptr_q[PTR_W-1:0]];
               state_d = StStart;
            end
         end
         StStart: begin
            tx = 1'b0;
            if (bit_done) begin
               timer_d   = '0;
               bit_idx_d = '0;
               state_d   = StData;
            end
         end
         StData: begin
            tx = shift_q[0];
            if (bit_done) begin
               timer_d = '0;
               shift_d = shift_q >> 1;
               if (bit_idx_q == 3'd7) state_d = StStop;
               else bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         StStop: begin
            if (bit_done) begin
               timer_d = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy = (state_q != StIdle) | !empty;

endmodule

// File: tb/tb_energy_telemetry_tx.sv
// Randomised and directed bench for energy_telemetry_tx; every cycle is compared against a
// transaction-level model (sample windows, FIFO queue, frame countdown).
module tb_energy_telemetry_tx;

   localparam int WIN   = 8;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sample_in = 8'h00;
   logic       sample_valid = 1'b0;
   logic       clear_ovf = 1'b0;
   logic [7:0] avg_out;
   logic       avg_valid, tx, overflow, busy;

   energy_telemetry_tx #(
      .LOG2_WIN    (3),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_in   (sample_in),
      .sample_valid(sample_valid),
      .clear_ovf   (clear_ovf),
      .avg_out     (avg_out),
      .avg_valid   (avg_valid),
      .tx          (tx),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model state: what the outputs should be after the latest modelled edge.
   int win_q[$];
   int fifo_q[$];
   int m_avg, m_avg_valid, m_ovf, tx_rem, tx_byte;

   function automatic int exp_tx();
      int slot;
      if (tx_rem == 0) return 1;
      slot = (FRAME - tx_rem) / CPB;
      if (slot == 0) return 0;
      if (slot == 9) return 1;
      return (tx_byte >> (slot - 1)) & 1;
   endfunction

   function automatic int exp_busy();
      return (tx_rem > 0 || fifo_q.size() > 0) ? 1 : 0;
   endfunction

   task automatic model_reset();
      win_q.delete();
      fifo_q.delete();
      m_avg = 0; m_avg_valid = 0; m_ovf = 0; tx_rem = 0; tx_byte = 0;
   endtask

   task automatic model_step(input bit sv, input int s, input bit co);
      bit pop, push, drop;
      int pushed, sum;
      pop    = (tx_rem == 0) && (fifo_q.size() > 0);
      push   = (m_avg_valid != 0);
      pushed = m_avg;
      drop   = push && (fifo_q.size() == DEPTH) && !pop;
      if (pop) begin
         tx_byte = fifo_q.pop_front();
         tx_rem  = FRAME;
      end else if (tx_rem > 0) begin
         tx_rem--;
      end
      if (push && !drop) fifo_q.push_back(pushed);
      if (drop) m_ovf = 1;
      else if (co) m_ovf = 0;
      m_avg_valid = 0;
      if (sv) begin
         win_q.push_back(s);
         if (win_q.size() == WIN) begin
            sum = 0;
            foreach (win_q[i]) sum += win_q[i];
            m_avg       = sum / WIN;
            m_avg_valid = 1;
            win_q.delete();
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("avg_out", avg_out, m_avg);
      check_eq("avg_valid", avg_valid, m_avg_valid);
      check_eq("tx", tx, exp_tx());
      check_eq("overflow", overflow, m_ovf);
      check_eq("busy", busy, exp_busy());
   endtask

   task automatic tick(input bit sv, input int s, input bit co);
      @(negedge clk);
      check_outputs();
      sample_valid = sv;
      sample_in    = 8'(s);
      clear_ovf    = co;
      model_step(sv, s, co);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sample_valid = 1'b0;
      clear_ovf = 1'b0;
      model_reset();
      #1 check_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_step(0, 0, 0);
   endtask

   task automatic run_window(input int v);
      for (int i = 0; i < WIN; i++) tick(1, v, 0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000 && (exp_busy() != 0 || m_avg_valid != 0); i++) tick(0, 0, 0);
      tick(0, 0, 0);
      check_eq("drained_busy", busy, 0);
   endtask

   initial begin
      model_reset();
      do_reset();

      // Constant window: exact average, frame follows.
      run_window(8'h40);
      tick(0, 0, 0);
      check_eq("win40_avg", avg_out, 8'h40);
      wait_idle();

      // Truncating average of 0xFF x7 + 0xFE.
      for (int i = 0; i < 7; i++) tick(1, 8'hFF, 0);
      tick(1, 8'hFE, 0);
      tick(0, 0, 0);
      check_eq("trunc_avg", avg_out, 8'hFE);
      wait_idle();

      // Six back-to-back windows: one in flight, four buffered, sixth dropped.
      for (int w = 1; w <= 6; w++) run_window(w);
      tick(0, 0, 0);
      wait_idle();
      check_eq("ovf_after_drop", overflow, 1);
      tick(0, 0, 1);
      tick(0, 0, 0);
      check_eq("ovf_cleared", overflow, 0);

      // Clear asserted in the very cycle a drop happens: set must win.
      for (int w = 1; w <= 6; w++) run_window(8'h20 + w);
      tick(0, 0, 1);
      tick(0, 0, 0);
      check_eq("ovf_set_wins", overflow, 1);
      wait_idle();
      tick(0, 0, 1);

      // Full FIFO with push and pop in the same cycle, repeated to wrap the pointers.
      for (int r = 0; r < 3; r++) begin
         for (int w = 0; w < 5; w++) run_window(8'h11 + 8 * r + w);
         for (int i = 0; i < 7; i++) tick(1, 8'h16 + 8 * r, 0);
         for (int i = 0; i < 400 && tx_rem != 1; i++) tick(0, 0, 0);
         check_eq("fifo_full_before_pp", fifo_q.size() == DEPTH ? 1 : 0, 1);
         tick(1, 8'h16 + 8 * r, 0);
         tick(0, 0, 0);
         tick(0, 0, 0);
         check_eq("pp_no_ovf", overflow, 0);
         wait_idle();
      end

      // Reset during data bit 3 of a frame.
      run_window(8'h30);
      for (int i = 0; i < 400 && !(tx_rem > 0 && (FRAME - tx_rem) / CPB == 4); i++)
         tick(0, 0, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_outputs();
      check_eq("rst_mid_tx", tx, 1);
      check_eq("rst_mid_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_step(0, 0, 0);
      run_window(8'h10);
      wait_idle();

      // Random traffic with varying strobe density and occasional clears.
      for (int blk = 0; blk < 10; blk++) begin
         int rate;
         rate = $urandom_range(1, 4);
         for (int i = 0; i < 250; i++)
            tick($urandom_range(0, 3) < rate, $urandom_range(0, 255), $urandom_range(0, 49) == 0);
      end
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
